// File: rtl/cpu_pkg.sv
// Shared core definitions: sequencer state encoding and architectural constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam logic [3:0] REG_PC     = 4'd15;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/ldm_stm_seq_lsb_prio_enc16.sv
// Lowest-set-bit priority encoder with popcount for a 16-bit register mask.
// Purely combinational, no backpressure.
module lsb_prio_enc16 (
    input  logic [15:0] i_mask,
    output logic [3:0]  o_idx,
    output logic        o_vld,
    output logic [4:0]  o_cnt
);

    always_comb begin
        o_idx = '0;
        o_cnt = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = 4'(i);
            end
            o_cnt = o_cnt + 5'(i_mask[i]);
        end
        o_vld = |i_mask;
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: one register per accepted memory beat, then optional base writeback.
// Holds each memory request stable until mem_ack; busy stalls the core while active.
module ldm_stm_seq
    import cpu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    load,
    input  logic                    up,
    input  logic                    pre,
    input  logic                    wb,
    input  logic [$clog2(NREG)-1:0] rn,
    input  logic [NREG-1:0]         reglist,
    input  logic [XLEN-1:0]         base,
    output logic [$clog2(NREG)-1:0] ra,
    input  logic [XLEN-1:0]         rd,
    output logic                    we3,
    output logic [$clog2(NREG)-1:0] wa3,
    output logic [XLEN-1:0]         wd3,
    output logic                    pc_load,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [XLEN-1:0]         mem_addr,
    output logic [XLEN-1:0]         mem_wdata,
    input  logic                    mem_ack,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic                    busy,
    output logic                    done
);

    seq_state_t      r_state;
    seq_state_t      w_next;
    logic            r_load;
    logic            r_wb_en;
    logic [3:0]      r_rn;
    logic [15:0]     r_mask;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_final;

    logic [15:0]     w_enc_in;
    logic [3:0]      w_cur;
    logic            w_vld;
    logic [4:0]      w_cnt;
    logic [XLEN-1:0] w_four_n;
    logic [XLEN-1:0] w_plus;
    logic [XLEN-1:0] w_minus;
    logic [XLEN-1:0] w_start_addr;
    logic [XLEN-1:0] w_final;
    logic            w_wb_en;

    // One encoder serves both phases: popcount of the new list while idle, lowest pending register otherwise.
    assign w_enc_in = (r_state == IDLE) ? reglist : r_mask;

    lsb_prio_enc16 u_enc (
        .i_mask (w_enc_in),
        .o_idx  (w_cur),
        .o_vld  (w_vld),
        .o_cnt  (w_cnt)
    );

    assign w_four_n     = XLEN'(w_cnt) * XLEN'(WORD_BYTES);
    assign w_plus       = base + w_four_n;
    assign w_minus      = base - w_four_n;
    assign w_start_addr = up ? (pre ? base + XLEN'(WORD_BYTES) : base)
                             : (pre ? w_minus : w_minus + XLEN'(WORD_BYTES));
    assign w_final      = up ? w_plus : w_minus;
    assign w_wb_en      = wb && (rn != REG_PC) && !(load && reglist[rn]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_load  <= 1'b0;
            r_wb_en <= 1'b0;
            r_rn    <= '0;
            r_mask  <= '0;
            r_addr  <= '0;
            r_final <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_load  <= load;
                        r_wb_en <= w_wb_en;
                        r_rn    <= rn;
                        r_mask  <= reglist;
                        r_addr  <= w_start_addr;
                        r_final <= w_final;
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        r_mask[w_cur] <= 1'b0;
                        r_addr        <= r_addr + XLEN'(WORD_BYTES);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        ra        = '0;
        we3       = 1'b0;
        wa3       = '0;
        wd3       = '0;
        pc_load   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = w_vld ? XFER : DONE;
                end
            end
            XFER: begin
                mem_req  = w_vld;
                mem_we   = ~r_load;
                mem_addr = r_addr;
                if (!r_load) begin
                    ra        = w_cur;
                    mem_wdata = rd;
                end
                if (mem_ack) begin
                    if (r_load) begin
                        wd3 = mem_rdata;
                        if (w_cur == REG_PC) begin
                            pc_load = 1'b1;
                        end else begin
                            we3 = 1'b1;
                            wa3 = w_cur;
                        end
                    end
                    if (w_cnt == 5'd1) begin
                        w_next = r_wb_en ? WB : DONE;
                    end
                end
            end
            WB: begin
                we3    = 1'b1;
                wa3    = r_rn;
                wd3    = r_final;
                w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: per-cycle expectation table plus a mid-operation reset sequence.
module tb_ldm_stm_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        load;
    logic        up;
    logic        pre;
    logic        wb;
    logic [3:0]  rn;
    logic [15:0] reglist;
    logic [31:0] base;
    logic [3:0]  ra;
    logic [31:0] rd;
    logic        we3;
    logic [3:0]  wa3;
    logic [31:0] wd3;
    logic        pc_load;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    ldm_stm_seq #(.XLEN(32), .NREG(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .load      (load),
        .up        (up),
        .pre       (pre),
        .wb        (wb),
        .rn        (rn),
        .reglist   (reglist),
        .base      (base),
        .ra        (ra),
        .rd        (rd),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .pc_load   (pc_load),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file read port: Ri holds i*0x11, R15 reads as PC+8.
    always_comb rd = (ra == 4'd15) ? 32'h0000_1008 : 32'(ra) * 32'h11;

    typedef struct {
        logic        load;
        logic        up;
        logic        pre;
        logic        wb;
        logic [3:0]  rn;
        logic [15:0] reglist;
        logic [31:0] base;
    } cmd_t;

    typedef struct {
        logic        st;
        int          c;
        logic        ack;
        logic [31:0] rdata;
        logic        busy;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ra;
        logic        we3;
        logic [3:0]  wa3;
        logic [31:0] wd3;
        logic        pc;
        logic        done;
    } vec_t;

    cmd_t cmds [5];
    vec_t tab [$];

    function automatic vec_t r(logic st, int c, logic ack, logic [31:0] rdata,
                               logic bsy, logic req, logic we, logic [31:0] addr,
                               logic [31:0] wdata, logic [3:0] ra_e, logic we3_e,
                               logic [3:0] wa3_e, logic [31:0] wd3_e, logic pc, logic dn);
        vec_t v;
        v.st = st; v.c = c; v.ack = ack; v.rdata = rdata;
        v.busy = bsy; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.ra = ra_e; v.we3 = we3_e; v.wa3 = wa3_e; v.wd3 = wd3_e; v.pc = pc; v.done = dn;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, compare on the falling edge.
    task automatic run_row(input vec_t v, input int idx);
        start     = v.st;
        mem_ack   = v.ack;
        mem_rdata = v.rdata;
        if (v.st) begin
            load    = cmds[v.c].load;
            up      = cmds[v.c].up;
            pre     = cmds[v.c].pre;
            wb      = cmds[v.c].wb;
            rn      = cmds[v.c].rn;
            reglist = cmds[v.c].reglist;
            base    = cmds[v.c].base;
        end
        @(negedge clk);
        n_checks++;
        if (busy !== v.busy || mem_req !== v.req || mem_we !== v.we || mem_addr !== v.addr ||
            mem_wdata !== v.wdata || ra !== v.ra || we3 !== v.we3 || wa3 !== v.wa3 ||
            wd3 !== v.wd3 || pc_load !== v.pc || done !== v.done) begin
            n_errors++;
            $display("FAIL row%0d: got busy=%b req=%b we=%b addr=%h wdata=%h ra=%0d we3=%b wa3=%0d wd3=%h pc=%b done=%b; expected busy=%b req=%b we=%b addr=%h wdata=%h ra=%0d we3=%b wa3=%0d wd3=%h pc=%b done=%b",
                     idx, busy, mem_req, mem_we, mem_addr, mem_wdata, ra, we3, wa3, wd3, pc_load, done,
                     v.busy, v.req, v.we, v.addr, v.wdata, v.ra, v.we3, v.wa3, v.wd3, v.pc, v.done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        cmds[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  16'h0016, 32'h100}; // STMIA r0!,{r1,r2,r4}
        cmds[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 16'h8030, 32'h200}; // LDMDB r13!,{r4,r5,r15}
        cmds[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  16'h000C, 32'h040}; // LDMIA r2!,{r2,r3}
        cmds[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1,  16'h8000, 32'h300}; // STMIB r1,{r15}
        cmds[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd3,  16'h0000, 32'h500}; // empty list, wb=1

        // STMIA with a stray start in cycle 2 that must be ignored
        tab.push_back(r(1, 0, 1, 0, 0, 0, 0, 32'h0,   32'h0,  0, 0, 0, 32'h0,   0, 0));
        tab.push_back(r(0, 0, 1, 0, 1, 1, 1, 32'h100, 32'h11, 1, 0, 0, 32'h0,   0, 0));
        tab.push_back(r(1, 4, 1, 0, 1, 1, 1, 32'h104, 32'h22, 2, 0, 0, 32'h0,   0, 0));
        tab.push_back(r(0, 0, 1, 0, 1, 1, 1, 32'h108, 32'h44, 4, 0, 0, 32'h0,   0, 0));
        tab.push_back(r(0, 0, 1, 0, 1, 0, 0, 32'h0,   32'h0,  0, 1, 0, 32'h10C, 0, 0));
        tab.push_back(r(0, 0, 1, 0, 1, 0, 0, 32'h0,   32'h0,  0, 0, 0, 32'h0,   0, 1));
        // LDMDB with PC load
        tab.push_back(r(1, 1, 1, 0, 0, 0, 0, 32'h0,   32'h0,  0, 0, 0,  32'h0, 0, 0));
        tab.push_back(r(0, 0, 1, 32'hAAAA0004, 1, 1, 0, 32'h1F4, 32'h0, 0, 1, 4, 32'hAAAA0004, 0, 0));
        tab.push_back(r(0, 0, 1, 32'hAAAA0005, 1, 1, 0, 32'h1F8, 32'h0, 0, 1, 5, 32'hAAAA0005, 0, 0));
        tab.push_back(r(0, 0, 1, 32'h00003000, 1, 1, 0, 32'h1FC, 32'h0, 0, 0, 0, 32'h00003000, 1, 0));
        tab.push_back(r(0, 0, 1, 0, 1, 0, 0, 32'h0,   32'h0,  0, 1, 13, 32'h1F4, 0, 0));
        tab.push_back(r(0, 0, 1, 0, 1, 0, 0, 32'h0,   32'h0,  0, 0, 0,  32'h0,   0, 1));
        // LDMIA loading its own base: loaded value wins, no WB cycle
        tab.push_back(r(1, 2, 1, 0,    0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0, 0, 0));
        tab.push_back(r(0, 0, 1, 32'hA, 1, 1, 0, 32'h40, 32'h0, 0, 1, 2, 32'hA, 0, 0));
        tab.push_back(r(0, 0, 1, 32'hB, 1, 1, 0, 32'h44, 32'h0, 0, 1, 3, 32'hB, 0, 0));
        tab.push_back(r(0, 0, 1, 0,    1, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0, 0, 1));
        // STMIB of PC with three stall cycles
        tab.push_back(r(1, 3, 0, 0, 0, 0, 0, 32'h0,   32'h0,    0,  0, 0, 32'h0, 0, 0));
        for (int k = 0; k < 3; k++)
            tab.push_back(r(0, 0, 0, 0, 1, 1, 1, 32'h304, 32'h1008, 15, 0, 0, 32'h0, 0, 0));
        tab.push_back(r(0, 0, 1, 0, 1, 1, 1, 32'h304, 32'h1008, 15, 0, 0, 32'h0, 0, 0));
        tab.push_back(r(0, 0, 1, 0, 1, 0, 0, 32'h0,   32'h0,    0,  0, 0, 32'h0, 0, 1));
        // Empty list
        tab.push_back(r(1, 4, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0));
        tab.push_back(r(0, 0, 1, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 1));
        tab.push_back(r(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0));

        reset_n = 1'b0; start = 1'b0; load = 1'b0; up = 1'b0; pre = 1'b0; wb = 1'b0;
        rn = '0; reglist = '0; base = '0; mem_ack = 1'b0; mem_rdata = '0;
        #2;
        check_bit("reset_busy",    busy,    1'b0);
        check_bit("reset_mem_req", mem_req, 1'b0);
        check_bit("reset_we3",     we3,     1'b0);
        check_bit("reset_done",    done,    1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tab.size(); i++) run_row(tab[i], i);

        // Mid-operation reset during STMIA cycle 2
        run_row(tab[0], 100);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        check_bit("pre_reset_mem_req", mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        check_bit("async_mem_req_drop", mem_req, 1'b0);
        check_bit("async_busy_drop",    busy,    1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_bit("reset_no_wb_we3", we3,  1'b0);
            check_bit("reset_no_done",   done, 1'b0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 12; i < 16; i++) run_row(tab[i], 200 + i);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ldm_stm_seq.md
Name: ldm_stm_seq

Overview:
Multi-cycle load/store-multiple sequencer for the 32-bit core. It drives the register file's read and write ports (ra, we3/wa3/wd3) and the data-memory request port. It walks a 16-bit register list, moving one register per accepted memory beat, then performs optional base writeback. It sits beside the datapath and holds the core stalled via busy while active.

Parameters:
XLEN, 32, data/address width
NREG, 16, architectural registers; register 15 is the PC

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle command strobe, accepted only when busy=0
load  in  1  1 = LDM, 0 = STM
up  in  1  U bit, 1 = increment
pre  in  1  P bit, 1 = before
wb  in  1  W bit, base writeback
rn  in  4  base register index
reglist  in  16  register list, bit i = Ri
base  in  XLEN  value of Rn, sampled at start
ra  out  4  regfile read address for STM data
rd  in  XLEN  regfile read data; combinational; PC+8 when ra=15
we3  out  1  regfile write enable
wa3  out  4  regfile write address
wd3  out  XLEN  regfile write data
pc_load  out  1  one-cycle strobe: wd3 is the new PC
mem_req  out  1  memory request valid
mem_we  out  1  1 = write
mem_addr  out  XLEN  word address
mem_wdata  out  XLEN  store data
mem_ack  in  1  request accepted; for reads, mem_rdata valid this cycle
mem_rdata  in  XLEN  load data
busy  out  1  sequencer not idle
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Assertion mid-operation aborts immediately: mem_req drops asynchronously, with no partial writeback.
- States are IDLE, XFER, WB and DONE. busy = (state != IDLE).
- IDLE, start=1: latch the command fields, mask = reglist, n = popcount(reglist).
  - Start address, mod 2^32: IA = base; IB = base+4; DA = base-4n+4; DB = base-4n.
  - Final base: up ? base+4n : base-4n.
  - Go to XFER if n>0, else DONE.
  - start while busy is ignored.
- XFER:
  - cur = lowest set bit of mask. mem_req=1, mem_addr = current address, mem_we = ~load.
  - STM: ra = cur, mem_wdata = rd.
  - The request and all request outputs hold stable until mem_ack.
  - On mem_ack: clear bit cur, add 4 to the address.
  - LDM, same ack cycle: if cur != 15, then we3=1, wa3=cur, wd3=mem_rdata. If cur = 15, then pc_load=1, wd3=mem_rdata, we3=0.
  - Last ack (mask becomes 0): go to WB if writeback applies, else DONE.
  - Throughput is one register per cycle when mem_ack is held high.
- Registers are always transferred lowest index to lowest address, ascending.
- Writeback applies iff wb=1 and rn != 15 and not (load and reglist[rn]). The loaded value wins over writeback.
- WB: one cycle, we3=1, wa3=rn, wd3=final base. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE. A new start is accepted in the cycle after DONE.
- we3, pc_load and mem_req are never asserted outside XFER/WB. STM never writes the regfile except in WB.
- Latency: start in cycle 0, first mem_req in cycle 1. With no stalls, done occurs in cycle n+1, or n+2 with WB.
- Empty list: no memory traffic, no writeback, done in cycle 1.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum seq_state_t {IDLE, XFER, WB, DONE}
  - REG_PC = 4'd15
  - WORD_BYTES = 4
- One sub-module, lsb_prio_enc16: a 16-bit mask goes in; it outputs the lowest set index (4 bits), a valid flag and popcount (5 bits). It is purely combinational.

Test Plan:
1. STMIA r0!,{r1,r2,r4}, base 0x100, mem_ack always 1, r1/r2/r4 = 0x11/0x22/0x44 -> writes (0x100,0x11), (0x104,0x22), (0x108,0x44) in cycles 1-3; WB r0=0x10C in cycle 4; done in cycle 5.
2. LDMDB r13!,{r4,r5,r15}, base 0x200 -> reads at 0x1F4/0x1F8/0x1FC; we3 for r4 and r5; pc_load with the word from 0x1FC; WB r13=0x1F4.
3. LDMIA r2!,{r2,r3}, base 0x40, rdata 0xA,0xB -> r2=0xA, r3=0xB, no WB cycle, done in cycle 3.
4. STMIB r1,{r15} with mem_ack low for cycles 1-3 -> mem_addr=base+4 and mem_wdata=PC+8 stable through the stall, single write, no WB.
5. Empty reglist with wb=1 -> mem_req never high, we3 never high, done in cycle 1. A start pulse during busy in test 1 has no effect.
6. reset_n low in cycle 2 of test 1 -> mem_req/busy drop at once, no WB. After release, a new command runs normally from IDLE.
